// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the reaction-time datapath.
// Used by the reaction-time counter, the score register bank and the display.
package score_pkg;

    // Default bit width of one reaction time
    localparam int SCORE_WIDTH = 13;

    // Default number of history entries kept by the score register bank
    localparam int SCORE_DEPTH = 8;

    // One reaction-time value at the default width
    typedef logic [SCORE_WIDTH-1:0] rt_t;

endpackage : score_pkg

// File: rtl/score_min_tracker.sv
// score_min_tracker: running all-time minimum of loaded reaction times.
// Best only ever decreases between flushes. Overwriting the history entry
// that holds the minimum does not raise it again.
// Built only when MIN_TRACK_EN is defined (see score_register_bank).
module score_min_tracker #(
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] best_o,
    output logic             best_valid_o
);

    logic [WIDTH-1:0] best_q, best_d;
    logic             valid_q, valid_d;

    // Next-state: flush on clear, take a strictly smaller (or first) value on load
    always_comb begin
        best_d  = best_q;
        valid_d = valid_q;
        if (clear_i) begin
            best_d  = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            if (!valid_q || (in_i < best_q)) begin
                best_d = in_i;
            end else begin
                best_d = best_q;
            end
            valid_d = 1'b1;
        end else begin
            best_d  = best_q;
            valid_d = valid_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            best_q  <= best_d;
            valid_q <= valid_d;
        end
    end

    assign best_o       = best_q;
    assign best_valid_o = valid_q;

endmodule : score_min_tracker

// File: rtl/score_register_bank.sv
// score_register_bank: circular history of reaction times.
// Stores each loaded value into a DEPTH-entry ring, exposing the newest entry,
// a registered indexed read (0 = newest), occupancy and a running minimum.
// When full, a new load silently overwrites the oldest entry.
// Optional feature macro: MIN_TRACK_EN builds the Best/BestValid tracker;
// without it Best and BestValid are tied to 0.
module score_register_bank
    import score_pkg::*;
#(
    parameter int WIDTH = SCORE_WIDTH,
    parameter int DEPTH = SCORE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             CLRN,
    input  logic [WIDTH-1:0] In,
    input  logic             Load,
    input  logic             Clear,
    input  logic [PTR_W-1:0] RdIdx,
    output logic [WIDTH-1:0] RdData,
    output logic [WIDTH-1:0] Latest,
    output logic [CNT_W-1:0] Count,
    output logic             Full,
    output logic [WIDTH-1:0] Best,
    output logic             BestValid
);

    // One extra bit so wp + DEPTH - 1 - RdIdx never overflows
    localparam int               SUM_W     = CNT_W + 1;
    localparam logic [PTR_W-1:0] WP_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(DEPTH);
    localparam logic [SUM_W-1:0] SUM_OFS   = SUM_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rddata_q, rddata_d;
    logic [WIDTH-1:0] latest_q, latest_d;
    logic             full_q, full_d;

    logic [SUM_W-1:0] rd_sum_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic             rd_valid_s;

    // Map a newest-relative index onto a ring slot; DEPTH need not be a power of 2
    always_comb begin
        rd_sum_s = SUM_W'(wp_q) + SUM_OFS - SUM_W'(RdIdx);
        if (rd_sum_s >= SUM_DEPTH) begin
            rd_ptr_s = PTR_W'(rd_sum_s - SUM_DEPTH);
        end else begin
            rd_ptr_s = PTR_W'(rd_sum_s);
        end
        rd_valid_s = (CNT_W'(RdIdx) < count_q);
    end

    // Next-state for ring, pointer, occupancy and read port; Clear beats Load
    always_comb begin
        mem_d    = mem_q;
        wp_d     = wp_q;
        count_d  = count_q;
        rddata_d = rddata_q;
        latest_d = latest_q;
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wp_d     = '0;
            count_d  = '0;
            rddata_d = '0;
            latest_d = '0;
        end else begin
            // Read uses pre-edge state, so a same-edge load is not yet visible
            if (rd_valid_s) begin
                rddata_d = mem_q[rd_ptr_s];
            end else begin
                rddata_d = '0;
            end
            if (Load) begin
                mem_d[wp_q] = In;
                latest_d    = In;
                if (wp_q == WP_LAST) begin
                    wp_d = '0;
                end else begin
                    wp_d = wp_q + PTR_W'(1);
                end
                if (count_q == CNT_MAX) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                wp_d    = wp_q;
                count_d = count_q;
            end
        end
        full_d = (count_d == CNT_MAX);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            mem_q    <= '{default: '0};
            wp_q     <= '0;
            count_q  <= '0;
            rddata_q <= '0;
            latest_q <= '0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            count_q  <= count_d;
            rddata_q <= rddata_d;
            latest_q <= latest_d;
            full_q   <= full_d;
        end
    end

    assign RdData = rddata_q;
    assign Latest = latest_q;
    assign Count  = count_q;
    assign Full   = full_q;

`ifdef MIN_TRACK_EN
    score_min_tracker #(
        .WIDTH (WIDTH)
    ) u_min_tracker (
        .clk_i        (Clock),
        .rst_ni       (CLRN),
        .clear_i      (Clear),
        .load_i       (Load),
        .in_i         (In),
        .best_o       (Best),
        .best_valid_o (BestValid)
    );
`else
    assign Best      = '0;
    assign BestValid = 1'b0;
`endif

endmodule : score_register_bank

// File: tb/tb_score_register_bank.sv
// tb_score_register_bank: scoreboard bench for score_register_bank.
// The reference history is a newest-first queue; each driven cycle pushes
// the expected post-edge outputs, which the scenario tasks pop and compare.
// Best expectations follow MIN_TRACK_EN (tied to 0 when undefined).
module tb_score_register_bank;
    import score_pkg::*;

    localparam int DEPTH = SCORE_DEPTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        rt_t              rdata;
        rt_t              latest;
        logic [CNT_W-1:0] count;
        logic             full;
        rt_t              best;
        logic             bvalid;
    } exp_t;

    logic             Clock = 1'b0;
    logic             CLRN;
    rt_t              In;
    logic             Load;
    logic             Clear;
    logic [PTR_W-1:0] RdIdx;
    rt_t              RdData;
    rt_t              Latest;
    logic [CNT_W-1:0] Count;
    logic             Full;
    rt_t              Best;
    logic             BestValid;

    int n_checks = 0;
    int n_pass   = 0;

    rt_t  hist[$];
    rt_t  m_latest;
    rt_t  m_best;
    logic m_bv;
    exp_t sb[$];

    score_register_bank #(
        .WIDTH (SCORE_WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clock     (Clock),
        .CLRN      (CLRN),
        .In        (In),
        .Load      (Load),
        .Clear     (Clear),
        .RdIdx     (RdIdx),
        .RdData    (RdData),
        .Latest    (Latest),
        .Count     (Count),
        .Full      (Full),
        .Best      (Best),
        .BestValid (BestValid)
    );

    always #5 Clock = ~Clock;

    function automatic void model_reset();
        hist.delete();
        m_latest = '0;
        m_best   = '0;
        m_bv     = 1'b0;
    endfunction

    // Drive one clock cycle, push the expected post-edge outputs, sample point = edge+1
    task automatic drive_cycle(input logic ld, input logic clr, input rt_t din, input int idx);
        exp_t e;
        Load  = ld;
        Clear = clr;
        In    = din;
        RdIdx = PTR_W'(idx);
        if (clr)                    e.rdata = '0;
        else if (idx < hist.size()) e.rdata = hist[idx];
        else                        e.rdata = '0;
        if (clr) begin
            model_reset();
        end else if (ld) begin
            hist.push_front(din);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            m_latest = din;
            if (!m_bv || din < m_best) m_best = din;
            m_bv = 1'b1;
        end
        e.latest = m_latest;
        e.count  = CNT_W'(hist.size());
        e.full   = (hist.size() == DEPTH);
`ifdef MIN_TRACK_EN
        e.best   = m_best;
        e.bvalid = m_bv;
`else
        e.best   = '0;
        e.bvalid = 1'b0;
`endif
        sb.push_back(e);
        @(posedge Clock);
        #1;
        Load  = 1'b0;
        Clear = 1'b0;
    endtask

    task automatic test_reset();
        CLRN = 1'b0; Load = 1'b0; Clear = 1'b0; In = '0; RdIdx = '0;
        model_reset();
        #12;
        n_checks++; if (RdData !== '0) $display("FAIL reset_rddata got %0d want 0", RdData); else n_pass++;
        n_checks++; if (Latest !== '0) $display("FAIL reset_latest got %0d want 0", Latest); else n_pass++;
        n_checks++; if (Count !== '0) $display("FAIL reset_count got %0d want 0", Count); else n_pass++;
        n_checks++; if (Full !== 1'b0) $display("FAIL reset_full got %0b want 0", Full); else n_pass++;
        n_checks++; if (Best !== '0) $display("FAIL reset_best got %0d want 0", Best); else n_pass++;
        n_checks++; if (BestValid !== 1'b0) $display("FAIL reset_bestvalid got %0b want 0", BestValid); else n_pass++;
        CLRN = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_basic_history();
        exp_t e;
        rt_t  vals[3];
        vals[0] = 13'd300; vals[1] = 13'd150; vals[2] = 13'd450;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, vals[i], 0);
            e = sb.pop_front();
            n_checks++; if (Latest !== e.latest) $display("FAIL basic_latest[%0d] got %0d want %0d", i, Latest, e.latest); else n_pass++;
            n_checks++; if (Count !== e.count) $display("FAIL basic_count[%0d] got %0d want %0d", i, Count, e.count); else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 1'b0, '0, k);
            e = sb.pop_front();
            n_checks++; if (RdData !== e.rdata) $display("FAIL basic_rd[%0d] got %0d want %0d", k, RdData, e.rdata); else n_pass++;
        end
        n_checks++; if (Best !== e.best) $display("FAIL basic_best got %0d want %0d", Best, e.best); else n_pass++;
        n_checks++; if (BestValid !== e.bvalid) $display("FAIL basic_bestvalid got %0b want %0b", BestValid, e.bvalid); else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        drive_cycle(1'b0, 1'b1, '0, 0);
        void'(sb.pop_front());
        for (int v = 1; v <= 10; v++) begin
            drive_cycle(1'b1, 1'b0, rt_t'(v), 0);
            e = sb.pop_front();
            n_checks++; if (Count !== e.count) $display("FAIL wrap_count[%0d] got %0d want %0d", v, Count, e.count); else n_pass++;
            n_checks++; if (Full !== e.full) $display("FAIL wrap_full[%0d] got %0b want %0b", v, Full, e.full); else n_pass++;
        end
        drive_cycle(1'b0, 1'b0, '0, 0);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL wrap_rd0 got %0d want %0d", RdData, e.rdata); else n_pass++;
        drive_cycle(1'b0, 1'b0, '0, DEPTH - 1);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL wrap_rd_oldest got %0d want %0d", RdData, e.rdata); else n_pass++;
        n_checks++; if (Best !== e.best) $display("FAIL wrap_best got %0d want %0d", Best, e.best); else n_pass++;
    endtask

    task automatic test_clear_priority();
        exp_t e;
        drive_cycle(1'b1, 1'b1, 13'd50, 0);
        e = sb.pop_front();
        n_checks++; if (Latest !== e.latest) $display("FAIL clr_latest got %0d want %0d", Latest, e.latest); else n_pass++;
        n_checks++; if (Count !== e.count) $display("FAIL clr_count got %0d want %0d", Count, e.count); else n_pass++;
        n_checks++; if (Full !== e.full) $display("FAIL clr_full got %0b want %0b", Full, e.full); else n_pass++;
        n_checks++; if (RdData !== e.rdata) $display("FAIL clr_rddata got %0d want %0d", RdData, e.rdata); else n_pass++;
        n_checks++; if (BestValid !== e.bvalid) $display("FAIL clr_bestvalid got %0b want %0b", BestValid, e.bvalid); else n_pass++;
        drive_cycle(1'b0, 1'b0, '0, 0);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL clr_dropped_load got %0d want %0d", RdData, e.rdata); else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_cycle(1'b1, 1'b0, 13'd77, 0);
        void'(sb.pop_front());
        drive_cycle(1'b1, 1'b0, 13'd88, 0);
        void'(sb.pop_front());
        #3;
        CLRN = 1'b0;
        model_reset();
        #1;
        n_checks++; if (Count !== '0) $display("FAIL arst_count got %0d want 0", Count); else n_pass++;
        n_checks++; if (Latest !== '0) $display("FAIL arst_latest got %0d want 0", Latest); else n_pass++;
        n_checks++; if (RdData !== '0) $display("FAIL arst_rddata got %0d want 0", RdData); else n_pass++;
        n_checks++; if (Best !== '0) $display("FAIL arst_best got %0d want 0", Best); else n_pass++;
        #2;
        CLRN = 1'b1;
        drive_cycle(1'b1, 1'b0, 13'd200, 0);
        e = sb.pop_front();
        n_checks++; if (Count !== e.count) $display("FAIL arst_reload_count got %0d want %0d", Count, e.count); else n_pass++;
        n_checks++; if (Best !== e.best) $display("FAIL arst_reload_best got %0d want %0d", Best, e.best); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_cycle(1'b1, 1'b0, 13'd100, 0);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL b2b_same_edge got %0d want %0d", RdData, e.rdata); else n_pass++;
        drive_cycle(1'b0, 1'b0, '0, 0);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL b2b_next_read got %0d want %0d", RdData, e.rdata); else n_pass++;
        drive_cycle(1'b1, 1'b0, 13'd0, 1);
        e = sb.pop_front();
        n_checks++; if (RdData !== e.rdata) $display("FAIL b2b_zero_load_rd got %0d want %0d", RdData, e.rdata); else n_pass++;
        n_checks++; if (Best !== e.best) $display("FAIL b2b_zero_best got %0d want %0d", Best, e.best); else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        for (int c = 0; c < 80; c++) begin
            drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                        rt_t'($urandom), int'($urandom_range(0, DEPTH - 1)));
            e = sb.pop_front();
            n_checks++; if (RdData !== e.rdata) $display("FAIL rnd_rd[%0d] got %0d want %0d", c, RdData, e.rdata); else n_pass++;
            n_checks++; if (Count !== e.count) $display("FAIL rnd_count[%0d] got %0d want %0d", c, Count, e.count); else n_pass++;
            n_checks++; if (Latest !== e.latest) $display("FAIL rnd_latest[%0d] got %0d want %0d", c, Latest, e.latest); else n_pass++;
            n_checks++; if (Best !== e.best) $display("FAIL rnd_best[%0d] got %0d want %0d", c, Best, e.best); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_history();
        test_wrap();
        test_clear_priority();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_score_register_bank

// File: doc/score_register_bank.md
Name: score_register_bank

Overview:
Parametrised bank of reaction-time registers for the game datapath. It captures each new WIDTH-bit reaction time into a circular history of DEPTH entries and exposes the newest entry, an indexed registered read port, an occupancy count and a running best (minimum) time. It sits between the reaction-time counter and the display/score logic, and replaces the fixed single-row register.

Parameters:
WIDTH, 13, bit width of one stored reaction time
DEPTH, 8, number of history entries; must be >= 2
PTR_W, $clog2(DEPTH), width of the write pointer and of RdIdx (derived; not overridden)
CNT_W, $clog2(DEPTH+1), width of Count (derived; not overridden)

Ports:
Clock  input  1  single system clock, rising edge
CLRN  input  1  asynchronous active-low reset
In  input  WIDTH  reaction time to store
Load  input  1  store In on this edge
Clear  input  1  synchronous flush of history and best
RdIdx  input  PTR_W  history index: 0 = newest, k = k-th older
RdData  output  WIDTH  registered read of entry RdIdx
Latest  output  WIDTH  newest stored entry
Count  output  CNT_W  number of valid entries, 0..DEPTH
Full  output  1  Count == DEPTH
Best  output  WIDTH  minimum value loaded since reset/Clear
BestValid  output  1  Best holds a real value

Behaviour:
- Reset (CLRN=0, asynchronous, any time): all storage entries, write pointer, Count, RdData, Latest and Best go to 0; Full and BestValid go to 0. Reset mid-operation discards everything.
- Write: on a rising edge with Load=1 and Clear=0, In goes to entry[wp] and wp advances by one modulo DEPTH. Count increments and saturates at DEPTH. Latest equals the value written from the cycle after the Load edge.
- Full: when Load occurs with Count==DEPTH, the oldest entry is overwritten and Count stays at DEPTH. There is no stall and no error flag.
- Clear=1 (synchronous): on that edge the state returns to the reset values. Clear has priority over a simultaneous Load, and that Load is dropped.
- Read: RdData is registered with 1-cycle latency. At edge t it captures entry[(wp-1-RdIdx) mod DEPTH] using the state before edge t, so a Load on the same edge is not visible until the next edge.
- If RdIdx >= Count, RdData captures 0.
- Best: on a Load edge, Best <= In if BestValid==0 or In < Best (unsigned compare); otherwise it holds. Ties hold. BestValid <= 1.
- Best is an all-time minimum and is not reduced when the entry holding it is overwritten.
- In value 0 is legal data and is stored normally.
- Arithmetic is unsigned throughout. Pointer wrap uses an explicit compare against DEPTH-1, because DEPTH need not be a power of 2.

Optional Feature:
MIN_TRACK_EN
- Defined: the Best/BestValid logic is built as described above.
- Undefined: no comparator or Best register is built; Best is tied to 0 and BestValid to 0. All other behaviour is identical.

Decomposition:
- Shared package score_pkg holds the default WIDTH (13), default DEPTH (8) and a typedef rt_t for the WIDTH-bit reaction-time value. It is shared with the counter and display blocks.
- One sub-module is natural: score_min_tracker, containing the comparator, the Best register and BestValid. It is instantiated only under MIN_TRACK_EN.

Test Plan:
1. Reset, then load 300, 150 and 450 (DEPTH=8) -> Latest=450, Count=3, Best=150, BestValid=1; RdIdx=0,1,2 give 450, 150, 300 one cycle later; RdIdx=3 gives 0.
2. Load 1..10 (DEPTH=8) -> Count=8, Full=1; RdIdx=0 gives 10, RdIdx=7 gives 3; Best=1 even though 1 has been overwritten.
3. Load=1 and Clear=1 on the same edge, with In=50 -> all outputs 0 next cycle and 50 is not stored.
4. Assert CLRN low mid-stream, between clock edges -> outputs 0 immediately, without waiting for an edge; the next Load 200 gives Count=1 and Best=200.
5. Load 100 and read RdIdx=0 on the same edge -> RdData shows the previous newest entry; 100 appears on the following read.
6. Build without MIN_TRACK_EN and load 5, 3 -> Best=0 and BestValid=0; history behaviour is unchanged.
